stage_dispatcher: RTL and testbench
===================================

Name: stage_dispatcher

Overview:
- Responder side of the master sequencing handshake. Master_FSM publishes `state` and consumes Conv_done/Avg_done/FC_done/Judge_done; this block produces those done pulses.
- Decodes each new master state and issues a one-cycle start to the matching layer engine (conv, avg-pool, FC, judge). It also supplies layer/sub-layer select.
- Waits for the engine's completion, then returns exactly one done pulse to the master.
- Sits between Master_FSM and the layer engines, and adds a watchdog timeout.

Parameters:
- STATE_DATAWIDTH, 4: width of master state bus.
- TIMEOUT_WIDTH, 16: watchdog counter width.
- TIMEOUT_CYCLES, 50000: max WAIT cycles before timeout; must be < 2^TIMEOUT_WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- state  in  STATE_DATAWIDTH  master state: 0 IDLE; 1/2/3 conv1_1/conv1_2/pool1; 4/5/6 layer 2; 7/8/9 layer 3; 10 FC; 11 JUDGE; 12-15 invalid
- eng_conv_done  in  1  conv engine completion pulse
- eng_avg_done  in  1  avg-pool engine completion pulse
- eng_fc_done  in  1  FC engine completion pulse
- eng_judge_done  in  1  judge engine completion pulse
- conv_start  out  1  one-cycle start to conv engine
- avg_start  out  1  one-cycle start to avg-pool engine
- fc_start  out  1  one-cycle start to FC engine
- judge_start  out  1  one-cycle start to judge engine
- layer_sel  out  2  layer index 0/1/2 for states 1-3/4-6/7-9
- conv_sub  out  1  0 for x_1 conv, 1 for x_2 conv
- Conv_done  out  1  one-cycle done to master
- Avg_done  out  1  one-cycle done to master
- FC_done  out  1  one-cycle done to master
- Judge_done  out  1  one-cycle done to master
- busy  out  1  high in LAUNCH/WAIT/REPORT
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset values: all outputs 0; FSM=D_IDLE; state_q=0; timer=0.
- state_q registers `state` every cycle. A "change" is state != state_q.
- A stage state is 1..11. States 0 and 12-15 are non-stage: never start anything.
- FSM states: D_IDLE, D_LAUNCH, D_WAIT, D_REPORT, D_HOLD.
- D_IDLE / D_HOLD: on change to a stage state -> D_LAUNCH and latch the target state; on change to a non-stage state -> D_IDLE.
  - Exception: leaving reset with state already a stage state counts as a change, because state_q resets to 0.
- D_LAUNCH (1 cycle):
  - exactly one start output high (conv for 1,2,4,5,7,8; avg for 3,6,9; fc for 10; judge for 11);
  - layer_sel/conv_sub updated from the latched state and held until the next LAUNCH;
  - timer cleared; next D_WAIT.
  - Start rises in the cycle after the edge at which the new state was first sampled.
- D_WAIT:
  - timer increments each cycle.
  - Matching engine done -> D_REPORT.
  - Non-matching engine dones are ignored.
  - Engine dones during LAUNCH are ignored.
- D_REPORT (1 cycle): the matching master done output is high for exactly this cycle (one cycle after engine done sampled); next D_HOLD.
- Master change during D_WAIT (abort): no done emitted; timer cleared; go to D_LAUNCH if the new state is a stage state, else D_IDLE.
- Simultaneous change and matching engine done in D_WAIT: the abort wins and no done is emitted.
- Timeout: if timer reaches TIMEOUT_CYCLES-1 in D_WAIT without a matching done -> timeout_err=1, no done, go to D_HOLD.
  - timeout_err clears only on reset.
- Done and start outputs are never high for more than 1 consecutive cycle.
- At most one start and at most one master done are high in any cycle.
- Same stage repeated (e.g. conv1_1 -> conv1_2) is a distinct change, so the dispatcher relaunches.
- Reset asserted mid-operation: all outputs drop asynchronously to reset values; the FSM returns to D_IDLE.

Test Plan:
- Full frame: master steps 0->1->...->11->0; each engine done returns 3 cycles after its start.
  - Required: one start per state.
  - layer_sel 0,0,0,1,1,1,2,2,2; conv_sub 0,1,x.
  - Conv_done 6 times, Avg_done 3, FC_done 1, Judge_done 1.
  - Each done is one cycle, arriving one cycle after the engine done.
- Mismatched done: state=3 (avg_start issued), then eng_conv_done pulses.
  - Required: no Avg_done/Conv_done.
  - A later eng_avg_done yields a single Avg_done.
- Timeout: TIMEOUT_CYCLES=20, state=10, no eng_fc_done.
  - Required: timeout_err rises on the 20th WAIT cycle and stays high; FC_done never asserts.
  - A later state 11 still launches judge_start.
- Abort: state=1, then state=4 after 2 WAIT cycles with no engine done.
  - Required: no Conv_done; a second conv_start with layer_sel=1, conv_sub=0.
- Invalid/idle: state=13, then state=0.
  - Required: no start, busy=0, no done.
- Reset mid-WAIT: state=7 and in WAIT, assert reset asynchronously mid-cycle.
  - Required: all outputs 0 immediately.
  - After deassert with state still 7, a fresh conv_start with layer_sel=2.

Source files
------------

// File: rtl/stage_dispatcher.sv
// stage_dispatcher: turns master state changes into one-cycle engine
// starts and returns exactly one done pulse per completed stage.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   state                      master state (1..11 stage, else idle)
//   eng_*_done                 engine completion pulses (conv/avg/fc/judge)
//   *_start                    one-cycle engine starts
//   layer_sel, conv_sub        layer index and x_1/x_2 conv select
//   Conv/Avg/FC/Judge_done     one-cycle dones back to the master
//   busy                       high while launching, waiting or reporting
//   timeout_err                sticky watchdog flag
module stage_dispatcher #(
    parameter int STATE_DATAWIDTH = 4,
    parameter int TIMEOUT_WIDTH   = 16,
    parameter int TIMEOUT_CYCLES  = 50000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [STATE_DATAWIDTH-1:0] state,
    input  logic                       eng_conv_done,
    input  logic                       eng_avg_done,
    input  logic                       eng_fc_done,
    input  logic                       eng_judge_done,
    output logic                       conv_start,
    output logic                       avg_start,
    output logic                       fc_start,
    output logic                       judge_start,
    output logic [1:0]                 layer_sel,
    output logic                       conv_sub,
    output logic                       Conv_done,
    output logic                       Avg_done,
    output logic                       FC_done,
    output logic                       Judge_done,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam logic [2:0] D_IDLE   = 3'd0;
    localparam logic [2:0] D_LAUNCH = 3'd1;
    localparam logic [2:0] D_WAIT   = 3'd2;
    localparam logic [2:0] D_REPORT = 3'd3;
    localparam logic [2:0] D_HOLD   = 3'd4;

    localparam logic [1:0] K_CONV  = 2'd0;
    localparam logic [1:0] K_AVG   = 2'd1;
    localparam logic [1:0] K_FC    = 2'd2;
    localparam logic [1:0] K_JUDGE = 2'd3;

    localparam logic [TIMEOUT_WIDTH-1:0] T_LAST =
        TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [2:0]                 fsm;
    logic [2:0]                 fsm_nx;
    logic [STATE_DATAWIDTH-1:0] state_q;
    logic [TIMEOUT_WIDTH-1:0]   timer;
    logic [1:0]                 tgt_kind;
    logic [31:0]                code;
    logic [5:0]                 dec;
    logic                       dec_stage;
    logic [1:0]                 dec_kind;
    logic [1:0]                 dec_layer;
    logic                       dec_sub;
    logic                       change;
    logic                       hit;
    logic                       timed_out;
    logic                       launch;
    logic                       report;

    assign code   = 32'(state);
    assign change = (state != state_q);

    // dec = {stage, kind, layer, sub}
    always_comb begin
        dec = 6'b0_00_00_0;
        unique case (code)
            32'd1:   dec = 6'b1_00_00_0;
            32'd2:   dec = 6'b1_00_00_1;
            32'd3:   dec = 6'b1_01_00_0;
            32'd4:   dec = 6'b1_00_01_0;
            32'd5:   dec = 6'b1_00_01_1;
            32'd6:   dec = 6'b1_01_01_0;
            32'd7:   dec = 6'b1_00_10_0;
            32'd8:   dec = 6'b1_00_10_1;
            32'd9:   dec = 6'b1_01_10_0;
            32'd10:  dec = 6'b1_10_00_0;
            32'd11:  dec = 6'b1_11_00_0;
            default: dec = 6'b0_00_00_0;
        endcase
    end

    assign {dec_stage, dec_kind, dec_layer, dec_sub} = dec;

    // Only the engine matching the launched stage may complete it.
    always_comb begin
        hit = 1'b0;
        unique case (tgt_kind)
            K_CONV:  hit = eng_conv_done;
            K_AVG:   hit = eng_avg_done;
            K_FC:    hit = eng_fc_done;
            K_JUDGE: hit = eng_judge_done;
            default: hit = 1'b0;
        endcase
    end

    // A master change in WAIT outranks an engine done arriving in
    // the same cycle: the stale stage is dropped without a done.
    always_comb begin
        fsm_nx    = fsm;
        timed_out = 1'b0;
        unique case (fsm)
            D_IDLE, D_HOLD: begin
                if (change)
                    fsm_nx = dec_stage ? D_LAUNCH : D_IDLE;
            end
            D_LAUNCH: fsm_nx = D_WAIT;
            D_WAIT: begin
                if (change) begin
                    fsm_nx = dec_stage ? D_LAUNCH : D_IDLE;
                end else if (hit) begin
                    fsm_nx = D_REPORT;
                end else if (timer == T_LAST) begin
                    fsm_nx    = D_HOLD;
                    timed_out = 1'b1;
                end
            end
            D_REPORT: fsm_nx = D_HOLD;
            default:  fsm_nx = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm         <= D_IDLE;
            state_q     <= '0;
            timer       <= '0;
            tgt_kind    <= K_CONV;
            layer_sel   <= 2'd0;
            conv_sub    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            fsm     <= fsm_nx;
            state_q <= state;
            if (fsm_nx == D_LAUNCH) begin
                tgt_kind  <= dec_kind;
                layer_sel <= dec_layer;
                conv_sub  <= dec_sub;
            end
            // Counts WAIT cycles; anything else (launch, abort) clears.
            if (fsm == D_WAIT && !change)
                timer <= timer + 1'b1;
            else
                timer <= '0;
            if (timed_out)
                timeout_err <= 1'b1;
        end
    end

    assign launch = (fsm == D_LAUNCH);
    assign report = (fsm == D_REPORT);

    assign conv_start  = launch && (tgt_kind == K_CONV);
    assign avg_start   = launch && (tgt_kind == K_AVG);
    assign fc_start    = launch && (tgt_kind == K_FC);
    assign judge_start = launch && (tgt_kind == K_JUDGE);

    assign Conv_done  = report && (tgt_kind == K_CONV);
    assign Avg_done   = report && (tgt_kind == K_AVG);
    assign FC_done    = report && (tgt_kind == K_FC);
    assign Judge_done = report && (tgt_kind == K_JUDGE);

    assign busy = launch || report || (fsm == D_WAIT);

endmodule

// File: tb/tb_stage_dispatcher.sv
// tb_stage_dispatcher: scoreboard bench for stage_dispatcher.
// Driver queues expected starts/dones; a negedge monitor pops them.
module tb_stage_dispatcher;

    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] state;
    logic       eng_conv_done;
    logic       eng_avg_done;
    logic       eng_fc_done;
    logic       eng_judge_done;
    logic       conv_start;
    logic       avg_start;
    logic       fc_start;
    logic       judge_start;
    logic [1:0] layer_sel;
    logic       conv_sub;
    logic       Conv_done;
    logic       Avg_done;
    logic       FC_done;
    logic       Judge_done;
    logic       busy;
    logic       timeout_err;

    stage_dispatcher #(
        .STATE_DATAWIDTH(4),
        .TIMEOUT_WIDTH(16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .state(state),
        .eng_conv_done(eng_conv_done),
        .eng_avg_done(eng_avg_done),
        .eng_fc_done(eng_fc_done),
        .eng_judge_done(eng_judge_done),
        .conv_start(conv_start),
        .avg_start(avg_start),
        .fc_start(fc_start),
        .judge_start(judge_start),
        .layer_sel(layer_sel),
        .conv_sub(conv_sub),
        .Conv_done(Conv_done),
        .Avg_done(Avg_done),
        .FC_done(FC_done),
        .Judge_done(Judge_done),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int layer;
        int sub;
        bit chk_layer;
        bit chk_sub;
        int at;
    } exp_t;

    exp_t sq[$];
    exp_t dq[$];
    int   dcnt[4];
    int   cur = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    // 0 conv, 1 avg, 2 fc, 3 judge
    function automatic int kind_of(int s);
        if (s == 10) return 2;
        if (s == 11) return 3;
        if (s % 3 == 0) return 1;
        return 0;
    endfunction

    function automatic bit is_stage(int s);
        return (s >= 1) && (s <= 11);
    endfunction

    function automatic int first_one(logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_eng(int k, logic v);
        case (k)
            0: eng_conv_done = v;
            1: eng_avg_done = v;
            2: eng_fc_done = v;
            default: eng_judge_done = v;
        endcase
    endtask

    // New master state; a stage state must start its engine next cycle.
    task automatic set_state(int s);
        exp_t e;
        state = 4'(s);
        cur = s;
        if (is_stage(s)) begin
            e.kind = kind_of(s);
            e.layer = (s <= 9) ? (s - 1) / 3 : 0;
            e.sub = ((s - 1) % 3 == 1) ? 1 : 0;
            e.chk_layer = (s <= 9);
            e.chk_sub = (s <= 9) && (e.kind == 0);
            e.at = cyc + 1;
            sq.push_back(e);
        end
    endtask

    // One-cycle engine done; a master done follows one cycle later.
    task automatic pulse(int k, bit expect_done);
        exp_t e;
        set_eng(k, 1'b1);
        if (expect_done) begin
            e.kind = k;
            e.layer = 0;
            e.sub = 0;
            e.chk_layer = 0;
            e.chk_sub = 0;
            e.at = cyc + 1;
            dq.push_back(e);
        end
        tick(1);
        set_eng(k, 1'b0);
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 4; i++) dcnt[i] = 0;
    endtask

    logic [3:0] sv;
    logic [3:0] dv;
    exp_t       me;

    always @(negedge clk) begin
        if (!reset) begin
            sv = {judge_start, fc_start, avg_start, conv_start};
            dv = {Judge_done, FC_done, Avg_done, Conv_done};
            if (sv != 4'd0) begin
                chk("start_onehot", $countones(sv), 1);
                if (sq.size() == 0) begin
                    chk("unexpected_start", int'(sv), 0);
                end else begin
                    me = sq.pop_front();
                    chk("start_engine", first_one(sv), me.kind);
                    chk("start_cycle", cyc, me.at);
                    if (me.chk_layer)
                        chk("layer_sel", int'(layer_sel), me.layer);
                    if (me.chk_sub)
                        chk("conv_sub", int'(conv_sub), me.sub);
                end
            end
            if (dv != 4'd0) begin
                chk("done_onehot", $countones(dv), 1);
                dcnt[first_one(dv)]++;
                if (dq.size() == 0) begin
                    chk("unexpected_done", int'(dv), 0);
                end else begin
                    me = dq.pop_front();
                    chk("done_kind", first_one(dv), me.kind);
                    chk("done_cycle", cyc, me.at);
                end
            end
        end
    end

    initial begin
        int s;
        int k;
        int w;
        int r;
        int d0;
        reset = 1'b1;
        state = 4'd0;
        eng_conv_done = 1'b0;
        eng_avg_done = 1'b0;
        eng_fc_done = 1'b0;
        eng_judge_done = 1'b0;
        clr_cnt();
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", int'({conv_start, avg_start, fc_start,
            judge_start, Conv_done, Avg_done, FC_done, Judge_done,
            busy, timeout_err, layer_sel, conv_sub}), 0);

        // full frame, engine done 3 cycles after each start
        tick(1);
        clr_cnt();
        for (int i = 1; i <= 11; i++) begin
            set_state(i);
            tick(4);
            pulse(kind_of(i), 1'b1);
            tick(1);
        end
        set_state(0);
        tick(3);
        chk("frame_conv_dones", dcnt[0], 6);
        chk("frame_avg_dones", dcnt[1], 3);
        chk("frame_fc_dones", dcnt[2], 1);
        chk("frame_judge_dones", dcnt[3], 1);

        // mismatched engine done is ignored
        clr_cnt();
        set_state(3);
        tick(3);
        pulse(0, 1'b0);
        tick(2);
        pulse(1, 1'b1);
        tick(1);
        chk("mismatch_conv_dones", dcnt[0], 0);
        chk("mismatch_avg_dones", dcnt[1], 1);

        // invalid then idle states
        set_state(13);
        tick(1);
        @(negedge clk);
        chk("invalid_busy", int'(busy), 0);
        tick(1);
        set_state(0);
        tick(2);
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // abort after 2 WAIT cycles
        tick(1);
        clr_cnt();
        set_state(1);
        tick(4);
        set_state(4);
        tick(4);
        pulse(0, 1'b1);
        tick(1);
        chk("abort_conv_dones", dcnt[0], 1);

        // change and matching done together: abort wins
        clr_cnt();
        set_state(5);
        tick(3);
        set_eng(0, 1'b1);
        set_state(7);
        tick(1);
        set_eng(0, 1'b0);
        tick(2);
        pulse(0, 1'b1);
        tick(1);
        chk("race_conv_dones", dcnt[0], 1);

        // randomized sessions
        for (int it = 0; it < 150; it++) begin
            do s = int'($urandom_range(0, 15)); while (s == cur);
            set_state(s);
            if (!is_stage(s)) begin
                tick(int'($urandom_range(1, 3)));
                continue;
            end
            k = kind_of(s);
            tick(1);
            if ($urandom_range(0, 3) == 0) pulse(k, 1'b0);
            else tick(1);
            w = int'($urandom_range(0, 6));
            repeat (w) begin
                if ($urandom_range(0, 2) == 0)
                    pulse((k + int'($urandom_range(1, 3))) % 4, 1'b0);
                else
                    tick(1);
            end
            r = int'($urandom_range(0, 9));
            if (r < 8) begin
                pulse(k, 1'b1);
                tick(1);
            end
        end
        if (cur != 0) set_state(0);
        tick(3);

        // watchdog
        chk("no_timeout_yet", int'(timeout_err), 0);
        clr_cnt();
        set_state(10);
        d0 = cyc;
        tick(21);
        @(negedge clk);
        chk("timeout_wait20_low", int'(timeout_err), 0);
        tick(1);
        @(negedge clk);
        chk("timeout_set", int'(timeout_err), 1);
        chk("timeout_cycle", cyc - d0, 22);
        chk("timeout_not_busy", int'(busy), 0);
        tick(10);
        chk("timeout_sticky", int'(timeout_err), 1);
        set_state(11);
        tick(3);
        pulse(3, 1'b1);
        tick(1);
        chk("timeout_fc_dones", dcnt[2], 0);
        chk("after_timeout_judge", dcnt[3], 1);
        chk("timeout_still_set", int'(timeout_err), 1);

        // async reset in WAIT
        set_state(7);
        tick(3);
        @(negedge clk);
        chk("prereset_busy", int'(busy), 1);
        chk("prereset_layer", int'(layer_sel), 2);
        tick(1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", int'({conv_start, avg_start, fc_start,
            judge_start, Conv_done, Avg_done, FC_done, Judge_done,
            busy, timeout_err, layer_sel, conv_sub}), 0);
        tick(2);
        reset = 1'b0;
        set_state(7);
        tick(3);
        pulse(0, 1'b1);
        tick(1);
        set_state(0);
        tick(3);

        chk("start_queue_empty", sq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
